// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH occasion gate.
package prach_pkg;

  localparam int SF_SAMPLES = 491520;
  localparam int NUM_SF     = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CP_SKIP = 2'd2,
    CAPTURE = 2'd3
  } prach_gate_state_t;

  // Mask lookup that treats out-of-range subframe numbers as "no occasion".
  function automatic logic sf_bit(input logic [NUM_SF-1:0] mask, input logic [3:0] sf);
    return (sf < 4'(NUM_SF)) ? mask[sf] : 1'b0;
  endfunction

endpackage

// File: rtl/prach_gate_cnt.sv
// Loadable down-counter of valid samples. term flags that the sample being
// counted this cycle is the last one; a load takes effect in the same cycle,
// so the first sample may arrive together with the load.
module prach_gate_cnt #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cur;

  assign cur  = load ? load_val : cnt_q;
  assign term = (cur == '0);

  // Remaining-minus-one register; holds at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (load || en)
      cnt_q <= (en && !term) ? cur - W'(1) : cur;
  end

endmodule

// File: rtl/prach_occasion_gate.sv
// PRACH occasion gate: detects configured occasions from the subframe marker
// and position, drops the CP and forwards one framed sequence per occasion.
import prach_pkg::*;

module prach_occasion_gate #(
  parameter int IQ_W  = 16,
  parameter int POS_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [NUM_SF-1:0] cfg_sf_mask,
  input  logic [POS_W-1:0]  cfg_start_offset,
  input  logic [POS_W-1:0]  cfg_cp_len,
  input  logic [POS_W-1:0]  cfg_seq_len,
  input  logic              sub_frame_mrkr,
  input  logic [3:0]        sub_frame_cnt,
  input  logic [POS_W-1:0]  sub_frame_sample_cnt,
  input  logic [IQ_W-1:0]   in_i,
  input  logic [IQ_W-1:0]   in_q,
  input  logic              in_valid,
  output logic [IQ_W-1:0]   out_i,
  output logic [IQ_W-1:0]   out_q,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [POS_W-1:0]  out_sample_idx,
  output logic [3:0]        occ_sf,
  output logic              busy,
  output logic              overrun_err,
  output logic              cfg_err
);

  prach_gate_state_t state, nxt;

  logic [POS_W-1:0] sh_off, sh_cp, sh_seq;
  logic [POS_W-1:0] idx_q, cur_idx;
  logic cfg_in_ok, start_cond, arm_hit, cp_zero;
  logic skip_ph, cap_ph, cp_load, cap_load, cp_en, cap_en, cp_term, cap_term;
  logic copy_cfg, arm_ld, in_occ;

  assign cfg_in_ok  = (cfg_seq_len != '0) && (cfg_start_offset <= POS_W'(SF_SAMPLES - 1));
  assign start_cond = sub_frame_mrkr && cfg_enable && sf_bit(cfg_sf_mask, sub_frame_cnt) && cfg_in_ok;
  assign in_occ     = (state == CP_SKIP) || (state == CAPTURE);
  assign cp_zero    = (sh_cp == '0);

  // The match cycle already belongs to the occasion: its sample is the first
  // CP sample, or the first sequence sample when there is no CP.
  assign arm_hit = (state == ARMED) && cfg_enable && (sub_frame_sample_cnt == sh_off);
  assign skip_ph = (state == CP_SKIP) || (arm_hit && !cp_zero);
  assign cap_ph  = (state == CAPTURE) || (arm_hit && cp_zero);

  assign cp_en    = skip_ph && in_valid;
  assign cap_en   = cap_ph && in_valid;
  assign cp_load  = arm_hit && !cp_zero;
  // Capture counter is preloaded on the last CP sample so it is ready when
  // the first sequence sample shows up, however many gaps follow.
  assign cap_load = (cp_en && cp_term) || (arm_hit && cp_zero);
  assign cur_idx  = cap_load ? '0 : idx_q;

  // Shadow config only tracks the inputs outside an occasion.
  assign copy_cfg = sub_frame_mrkr && (state == IDLE || state == ARMED) && !arm_hit;

  prach_gate_cnt #(.W(POS_W)) u_cp_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cp_load),
    .load_val (sh_cp - POS_W'(1)),
    .en       (cp_en),
    .term     (cp_term)
  );

  prach_gate_cnt #(.W(POS_W)) u_cap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cap_load),
    .load_val (sh_seq - POS_W'(1)),
    .en       (cap_en),
    .term     (cap_term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state; an active occasion outranks disable and markers.
  always_comb begin
    nxt    = state;
    arm_ld = 1'b0;
    if (cap_ph)
      nxt = (cap_en && cap_term) ? IDLE : CAPTURE;
    else if (skip_ph)
      nxt = (cp_en && cp_term) ? CAPTURE : CP_SKIP;
    else if (state == ARMED && !cfg_enable)
      nxt = IDLE;
    else if ((state == IDLE || state == ARMED) && sub_frame_mrkr) begin
      nxt    = start_cond ? ARMED : IDLE;
      arm_ld = start_cond;
    end
  end

  // Shadow config, occasion subframe and sticky config error.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_off  <= '0;
      sh_cp   <= '0;
      sh_seq  <= '0;
      occ_sf  <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (copy_cfg) begin
        sh_off <= cfg_start_offset;
        sh_cp  <= cfg_cp_len;
        sh_seq <= cfg_seq_len;
        if (!cfg_in_ok) cfg_err <= 1'b1;
      end
      if (arm_ld) occ_sf <= sub_frame_cnt;
    end
  end

  // Forwarded-sample index within the occasion.
  always_ff @(posedge clk) begin
    if (reset)       idx_q <= '0;
    else if (cap_en) idx_q <= cur_idx + POS_W'(1);
    else             idx_q <= cur_idx;
  end

  // Single output register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_i          <= '0;
      out_q          <= '0;
      out_valid      <= 1'b0;
      out_sop        <= 1'b0;
      out_eop        <= 1'b0;
      out_sample_idx <= '0;
      overrun_err    <= 1'b0;
    end else begin
      out_i          <= cap_en ? in_i : '0;
      out_q          <= cap_en ? in_q : '0;
      out_valid      <= cap_en;
      out_sop        <= cap_en && (cur_idx == '0);
      out_eop        <= cap_en && cap_term;
      out_sample_idx <= cap_en ? cur_idx : '0;
      overrun_err    <= start_cond && in_occ;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_prach_occasion_gate.sv
// Randomized bench for prach_occasion_gate with a sample-count reference model.
// Subframes are shortened to P cycles; the gate only sees positions, not length.
module tb_prach_occasion_gate;

  localparam int IQ_W  = 16;
  localparam int POS_W = 19;
  localparam int P     = 200;
  localparam int FRAME = 10 * P;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_enable;
  logic [9:0]        cfg_sf_mask;
  logic [POS_W-1:0]  cfg_start_offset, cfg_cp_len, cfg_seq_len;
  logic              sub_frame_mrkr;
  logic [3:0]        sub_frame_cnt;
  logic [POS_W-1:0]  sub_frame_sample_cnt;
  logic [IQ_W-1:0]   in_i, in_q;
  logic              in_valid;
  logic [IQ_W-1:0]   out_i, out_q;
  logic              out_valid, out_sop, out_eop;
  logic [POS_W-1:0]  out_sample_idx;
  logic [3:0]        occ_sf;
  logic              busy, overrun_err, cfg_err;

  prach_occasion_gate #(.IQ_W(IQ_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_sf_mask(cfg_sf_mask),
    .cfg_start_offset(cfg_start_offset), .cfg_cp_len(cfg_cp_len), .cfg_seq_len(cfg_seq_len),
    .sub_frame_mrkr(sub_frame_mrkr), .sub_frame_cnt(sub_frame_cnt),
    .sub_frame_sample_cnt(sub_frame_sample_cnt), .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_sample_idx(out_sample_idx), .occ_sf(occ_sf), .busy(busy),
    .overrun_err(overrun_err), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int g = 0;                 // global cycle -> frame position
  int vmode = 0, vprob = 50; // 0 always valid, 1 alternate, 2 random

  // reference model: occasion-level bookkeeping in plain integers
  bit m_armed, m_active, m_err;
  int m_n, m_occ, sh_off, sh_cp, sh_seq;
  bit e_valid, e_sop, e_eop, e_ovr;
  int e_idx;
  logic [IQ_W-1:0] e_i, e_q;

  // directed statistics gathered from DUT outputs
  int n_sop, n_eop, n_val, n_ovr, sop_sc, sop_g, eop_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_sop = 0; n_eop = 0; n_val = 0; n_ovr = 0; sop_sc = -1; sop_g = -1; eop_g = -1;
  endtask

  // the in_valid sample of a running occasion: n counts samples since the match
  task automatic take();
    if (in_valid) begin
      if (m_n >= sh_cp) begin
        e_valid = 1; e_idx = m_n - sh_cp;
        e_sop = (e_idx == 0); e_eop = (e_idx == sh_seq - 1);
        e_i = in_i; e_q = in_q;
      end
      m_n++;
      if (m_n == sh_cp + sh_seq) m_active = 0;
    end
  endtask

  task automatic model();
    bit ok_in, sc;
    ok_in = (cfg_seq_len != 0) && (int'(cfg_start_offset) <= 491519);
    sc = sub_frame_mrkr && cfg_enable && cfg_sf_mask[sub_frame_cnt] && ok_in;
    e_valid = 0; e_sop = 0; e_eop = 0; e_ovr = 0;
    if (reset) begin
      m_armed = 0; m_active = 0; m_err = 0; m_n = 0; m_occ = 0;
      sh_off = 0; sh_cp = 0; sh_seq = 0;
    end else if (m_active) begin
      e_ovr = sc;
      take();
    end else if (m_armed && cfg_enable && int'(sub_frame_sample_cnt) == sh_off) begin
      m_armed = 0; m_active = 1; m_n = 0;
      take();
    end else if (sub_frame_mrkr) begin
      sh_off = int'(cfg_start_offset); sh_cp = int'(cfg_cp_len); sh_seq = int'(cfg_seq_len);
      if (!ok_in) m_err = 1;
      m_armed = sc;
      if (sc) m_occ = int'(sub_frame_cnt);
    end else if (!cfg_enable) begin
      m_armed = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sub_frame_sample_cnt = POS_W'(g % P);
    sub_frame_cnt        = 4'((g / P) % 10);
    sub_frame_mrkr       = ((g % P) == 0);
    in_i = IQ_W'($urandom);
    in_q = IQ_W'($urandom);
    case (vmode)
      0:       in_valid = 1'b1;
      1:       in_valid = ((g % 2) == 0);
      default: in_valid = ($urandom_range(99) < vprob);
    endcase
    model();
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, e_valid);
    chk("out_sop", out_sop, e_sop);
    chk("out_eop", out_eop, e_eop);
    if (e_valid) begin
      chk("out_i", out_i, e_i);
      chk("out_q", out_q, e_q);
      chk("out_sample_idx", out_sample_idx, e_idx);
    end
    chk("busy", busy, m_armed || m_active);
    chk("overrun_err", overrun_err, e_ovr);
    chk("cfg_err", cfg_err, m_err);
    chk("occ_sf", occ_sf, m_occ);
    if (out_valid) n_val++;
    if (out_valid && out_sop) begin n_sop++; sop_sc = (g + 1) % P; sop_g = g; end
    if (out_eop) begin n_eop++; eop_g = g; end
    if (overrun_err) n_ovr++;
    g++;
  endtask

  task automatic to_frame();
    while ((g % FRAME) != 0) step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_cfg(input logic [9:0] mask, input int off, input int cp, input int seq);
    cfg_sf_mask = mask;
    cfg_start_offset = POS_W'(off);
    cfg_cp_len = POS_W'(cp);
    cfg_seq_len = POS_W'(seq);
  endtask

  initial begin
    reset = 1'b1; cfg_enable = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0;
    sub_frame_mrkr = 1'b0; sub_frame_cnt = '0; sub_frame_sample_cnt = '0;
    set_cfg(10'b0, 0, 0, 0);

    // reset state
    run(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;

    // nominal occasion, continuous samples
    set_cfg(10'b0000000001, 40, 30, 100);
    vmode = 0;
    to_frame(); clr_stats(); run(2 * FRAME);
    chk("t1_sops", n_sop, 2);
    chk("t1_eops", n_eop, 2);
    chk("t1_sop_pos", sop_sc, 40 + 30 + 1);
    chk("t1_eop_gap", eop_g - sop_g, 99);
    chk("t1_samples", n_val, 200);
    chk("t1_occ_sf", occ_sf, 0);

    // alternating in_valid: occasion stretches across the sf1 boundary
    vmode = 1;
    to_frame(); clr_stats(); run(2 * FRAME);
    chk("t2_samples", n_val, 200);
    chk("t2_eops", n_eop, 2);
    chk("t2_sop_pos", sop_sc, 101);
    chk("t2_eop_gap", eop_g - sop_g, 198);

    // sf1 start lands inside the sf0 capture
    vmode = 0;
    set_cfg(10'b0000000011, 40, 30, 300);
    to_frame(); clr_stats(); run(2 * FRAME);
    chk("t3_overruns", n_ovr, 2);
    chk("t3_eops", n_eop, 2);
    chk("t3_samples", n_val, 600);

    // no CP, single-sample sequence
    set_cfg(10'b0000000001, 7, 0, 1);
    to_frame(); clr_stats(); run(FRAME);
    chk("t4_sops", n_sop, 1);
    chk("t4_sop_eop_same", sop_g, eop_g);
    chk("t4_sop_pos", sop_sc, 8);

    // reset in the middle of a capture
    set_cfg(10'b0000000001, 40, 30, 100);
    to_frame();
    while ((g % P) != 120) step();
    clr_stats();
    reset = 1'b1; step();
    chk("t5_valid_after_rst", out_valid, 0);
    chk("t5_busy_after_rst", busy, 0);
    reset = 1'b0;
    to_frame(); run(FRAME);
    chk("t5_eops", n_eop, 1);
    chk("t5_samples", n_val, 100);

    // invalid configs, then recovery
    set_cfg(10'h3FF, 40, 30, 0);
    to_frame(); clr_stats(); run(FRAME);
    chk("t6_seq0_err", cfg_err, 1);
    chk("t6_seq0_samples", n_val, 0);
    set_cfg(10'h3FF, 491520, 30, 10);
    clr_stats(); run(FRAME);
    chk("t6_off_err", cfg_err, 1);
    chk("t6_off_samples", n_val, 0);
    reset = 1'b1; run(2); reset = 1'b0;
    set_cfg(10'b0000000001, 40, 30, 100);
    to_frame(); clr_stats(); run(FRAME);
    chk("t6_recover_err", cfg_err, 0);
    chk("t6_recover_eops", n_eop, 1);

    // random configs, gaps and enable drops against the model
    vmode = 2;
    for (int sf = 0; sf < 60; sf++) begin
      int kr;
      kr = $urandom_range(P - 1);
      vprob = $urandom_range(100, 30);
      for (int k = 0; k < P; k++) begin
        if (k == kr) begin
          set_cfg(10'($urandom), ($urandom_range(19) == 0) ? 491520 : $urandom_range(P - 1, 1),
                  $urandom_range(60), ($urandom_range(19) == 0) ? 0 : $urandom_range(150, 1));
          cfg_enable = ($urandom_range(7) != 0);
        end
        step();
      end
      if ((sf % 20) == 19) begin
        reset = 1'b1; step(); reset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
